// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- registered program counter for the ARM-LP fetch stage.
//
// Holds the fetch address in a register and offers it to instruction memory
// over a valid/ready handshake. Branches resolved in execute redirect fetch
// relative to the branch's own PC. Also supports stall and halt, and exports
// the scaled branch offset, a link address and an accepted-fetch counter.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   When defined, a taken branch to a misaligned target is not loaded.
//   Instead the sticky alignFault output is raised and the unit halts.
//   When undefined, the alignFault port does not exist and a misaligned
//   target is loaded unchanged.
//
// Ports:
//   clk                     in   rising-edge clock
//   reset                   in   synchronous, active-high reset
//   brValid                 in   branch-resolution inputs valid this cycle
//   branchFlag              in   conditional branch (CBZ/B.cond) in execute
//   unconditionalBranchFlag in   unconditional branch (B/BL)
//   zeroFlag                in   ALU zero result
//   brPC        [ADDR_W]    in   address of the resolving branch
//   PCOffsetOrig[OFFSET_W]  in   signed offset, counted in instructions
//   stall                   in   freezes the sequential advance
//   halt                    in   request to stop fetching
//   fetchReady              in   instruction memory accepts the address
//   fetchValid              out  readAddress is a valid fetch request
//   readAddress [ADDR_W]    out  current fetch address (registered)
//   PCScaledOffset[ADDR_W]  out  sign-extended offset * INSTR_BYTES
//   linkAddress [ADDR_W]    out  brPC + INSTR_BYTES (BL return address)
//   takenBranch             out  high the cycle after a redirect is applied
//   halted                  out  unit is in the HALT state
//   fetchCount  [COUNT_W]   out  number of accepted fetches (wraps)
//   alignFault              out  sticky misaligned-target flag (macro only)
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_BYTES  = 4,
  parameter int                OFFSET_W     = 26,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                COUNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       brValid,
  input  logic                       branchFlag,
  input  logic                       unconditionalBranchFlag,
  input  logic                       zeroFlag,
  input  logic        [ADDR_W-1:0]   brPC,
  input  logic signed [OFFSET_W-1:0] PCOffsetOrig,
  input  logic                       stall,
  input  logic                       halt,
  input  logic                       fetchReady,
  output logic                       fetchValid,
  output logic        [ADDR_W-1:0]   readAddress,
  output logic        [ADDR_W-1:0]   PCScaledOffset,
  output logic        [ADDR_W-1:0]   linkAddress,
  output logic                       takenBranch,
  output logic                       halted,
  output logic        [COUNT_W-1:0]  fetchCount
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                       alignFault
`endif
);

  localparam int unsigned       SHIFT = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INSTR_BYTES);
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
`endif

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic                taken_q, taken_d;
`ifdef PC_ALIGN_CHECK_EN
  logic                fault_q, fault_d;
`endif

  logic                take;
  logic                accept;
  logic [ADDR_W-1:0]   target;

  // The offset is sign-extended to the full address width before scaling,
  // so backward branches produce the correct two's-complement distance.
  assign PCScaledOffset = ADDR_W'(PCOffsetOrig) << SHIFT;
  assign linkAddress    = brPC + STEP;
  assign target         = brPC + PCScaledOffset;

  assign take   = brValid & ((zeroFlag & branchFlag) | unconditionalBranchFlag);
  assign accept = fetchValid & fetchReady;

  assign fetchValid  = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
  assign readAddress = addr_q;
  assign takenBranch = taken_q;
  assign fetchCount  = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
  assign alignFault  = fault_q;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    taken_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        // The counter sees every accept, even when a redirect overrides
        // the address update in the same cycle.
        if (accept) cnt_d = cnt_q + COUNT_W'(1);
        // A redirect wins over stall and backpressure; an unaccepted
        // request at the old address is simply abandoned.
        if (take) begin
`ifdef PC_ALIGN_CHECK_EN
          if ((target & ALIGN_MASK) != '0) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            addr_d  = target;
            taken_d = 1'b1;
          end
`else
          addr_d  = target;
          taken_d = 1'b1;
`endif
        end else if (accept && !stall) begin
          addr_d = addr_q + STEP;
        end
        // This cycle's update has already been computed above; halting
        // only freezes the address from the next cycle onwards.
        if (halt) state_d = S_HALT;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      addr_q  <= RESET_VECTOR;
      cnt_q   <= '0;
      taken_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
`ifdef PC_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit.
// Directed vector table, a hand-written misaligned-target sequence, then a
// randomized run compared against a behavioural model. COUNT_W is shrunk to
// 4 so that fetchCount wrap-around is exercised.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  localparam int          AW = 32;
  localparam int          OW = 26;
  localparam int          CW = 4;
  localparam int          IB = 4;
  localparam logic [31:0] RV = 32'h100;

  logic                 clk;
  logic                 reset;
  logic                 brValid, branchFlag, unconditionalBranchFlag, zeroFlag;
  logic        [AW-1:0] brPC;
  logic signed [OW-1:0] PCOffsetOrig;
  logic                 stall, halt, fetchReady;
  logic                 fetchValid;
  logic        [AW-1:0] readAddress, PCScaledOffset, linkAddress;
  logic                 takenBranch, halted;
  logic        [CW-1:0] fetchCount;
`ifdef PC_ALIGN_CHECK_EN
  logic                 alignFault;
`endif

  pc_unit #(
    .ADDR_W(AW), .INSTR_BYTES(IB), .OFFSET_W(OW),
    .RESET_VECTOR(RV), .COUNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .brValid(brValid), .branchFlag(branchFlag),
    .unconditionalBranchFlag(unconditionalBranchFlag), .zeroFlag(zeroFlag),
    .brPC(brPC), .PCOffsetOrig(PCOffsetOrig),
    .stall(stall), .halt(halt), .fetchReady(fetchReady),
    .fetchValid(fetchValid), .readAddress(readAddress),
    .PCScaledOffset(PCScaledOffset), .linkAddress(linkAddress),
    .takenBranch(takenBranch), .halted(halted), .fetchCount(fetchCount)
`ifdef PC_ALIGN_CHECK_EN
    , .alignFault(alignFault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // One record = inputs held for one cycle plus the outputs expected in
  // that same cycle (registered outputs reflect the previous edge).
  typedef struct {
    logic        rst, bv, bf, uf, zf;
    logic [31:0] brpc;
    logic [25:0] off;
    logic        st, hl, rdy;
    logic        ev;
    logic [31:0] ea;
    logic        et, eh;
    logic [3:0]  ec;
    logic [31:0] el, es;
  } vec_t;

  function automatic vec_t mk(input logic rst, bv, bf, uf, zf,
                              input logic [31:0] brpc, input int off,
                              input logic st, hl, rdy, ev,
                              input logic [31:0] ea, input logic et, eh,
                              input int ec, input logic [31:0] el, es);
    vec_t v;
    v.rst = rst; v.bv = bv; v.bf = bf; v.uf = uf; v.zf = zf;
    v.brpc = brpc; v.off = 26'(off); v.st = st; v.hl = hl; v.rdy = rdy;
    v.ev = ev; v.ea = ea; v.et = et; v.eh = eh; v.ec = 4'(ec);
    v.el = el; v.es = es;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    reset = v.rst; brValid = v.bv; branchFlag = v.bf;
    unconditionalBranchFlag = v.uf; zeroFlag = v.zf;
    brPC = v.brpc; PCOffsetOrig = v.off;
    stall = v.st; halt = v.hl; fetchReady = v.rdy;
    @(negedge clk);
    chk({tag, ".fetchValid"},  32'(fetchValid),  32'(v.ev));
    chk({tag, ".readAddress"}, readAddress,      v.ea);
    chk({tag, ".takenBranch"}, 32'(takenBranch), 32'(v.et));
    chk({tag, ".halted"},      32'(halted),      32'(v.eh));
    chk({tag, ".fetchCount"},  32'(fetchCount),  32'(v.ec));
    chk({tag, ".linkAddress"}, linkAddress,      v.el);
    chk({tag, ".scaledOff"},   PCScaledOffset,   v.es);
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: mode 0 = boot, 1 = running, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_taken;
  bit          m_fault;

  function automatic logic [31:0] ref_scaled(input logic signed [25:0] off);
    longint so;
    so = longint'(off);
    return 32'(so * IB);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = RV; m_cnt = 0; m_taken = 0; m_fault = 0;
  endtask

  task automatic model_step();
    bit          tk, bad, nxt;
    logic [31:0] tgt;
    if (reset) begin
      model_reset();
    end else if (m_mode == 0) begin
      m_mode = 1; m_taken = 0;
    end else if (m_mode == 2) begin
      m_taken = 0;
    end else begin
      nxt = 0;
      bad = 0;
      tk  = brValid && ((zeroFlag && branchFlag) || unconditionalBranchFlag);
      tgt = brPC + ref_scaled(PCOffsetOrig);
      if (fetchReady) m_cnt = (m_cnt + 1) % (1 << CW);
`ifdef PC_ALIGN_CHECK_EN
      bad = (tgt % IB) != 0;
`endif
      if (tk) begin
        if (bad) begin
          m_fault = 1; m_mode = 2;
        end else begin
          m_pc = tgt; nxt = 1;
        end
      end else if (fetchReady && !stall) begin
        m_pc = m_pc + IB;
      end
      if (halt) m_mode = 2;
      m_taken = nxt;
    end
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; brValid = 0; branchFlag = 0; unconditionalBranchFlag = 0;
    zeroFlag = 0; brPC = '0; PCOffsetOrig = '0; stall = 0; halt = 0;
    fetchReady = 0;
    @(posedge clk);
    #1;

    //            rst bv bf uf zf brpc          off st hl rdy | ev addr        et eh cnt link          scaled
    tbl.push_back(mk(1,0,0,0,0, 32'h0,         0, 0,0,1, 0,32'h100,     0,0,0, 32'h4,        32'h0));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,         0, 0,0,1, 0,32'h100,     0,0,0, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,1, 0,32'h100,     0,0,0, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,1, 1,32'h100,     0,0,0, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,1, 1,32'h104,     0,0,1, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,1, 1,32'h108,     0,0,2, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,0, 1,32'h10C,     0,0,3, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,0, 1,32'h10C,     0,0,3, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,0, 1,32'h10C,     0,0,3, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 1,0,1, 1,32'h10C,     0,0,3, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 1,0,1, 1,32'h10C,     0,0,4, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,1, 1,32'h10C,     0,0,5, 32'h4,        32'h0));
    tbl.push_back(mk(0,1,1,0,1, 32'h200,      -2, 0,0,1, 1,32'h110,     0,0,6, 32'h204,      32'hFFFFFFF8));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,0, 1,32'h1F8,     1,0,7, 32'h4,        32'h0));
    tbl.push_back(mk(0,1,1,0,0, 32'h200,      -2, 0,0,1, 1,32'h1F8,     0,0,7, 32'h204,      32'hFFFFFFF8));
    tbl.push_back(mk(0,1,0,1,0, 32'hFFFFFFF8,  3, 1,0,0, 1,32'h1FC,     0,0,8, 32'hFFFFFFFC, 32'hC));
    tbl.push_back(mk(0,1,0,1,0, 32'h2F0,       4, 0,1,1, 1,32'h4,       1,0,8, 32'h2F4,      32'h10));
    tbl.push_back(mk(0,1,0,1,0, 32'h500,       0, 0,0,1, 0,32'h300,     1,1,9, 32'h504,      32'h0));
    tbl.push_back(mk(0,1,0,1,0, 32'h500,       0, 0,0,1, 0,32'h300,     0,1,9, 32'h504,      32'h0));
    tbl.push_back(mk(1,1,0,1,0, 32'h500,       0, 0,0,1, 0,32'h300,     0,1,9, 32'h504,      32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,1, 0,32'h100,     0,0,0, 32'h4,        32'h0));
    tbl.push_back(mk(0,1,0,1,0, 32'h100,       0, 0,0,0, 1,32'h100,     0,0,0, 32'h104,      32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,0, 1,32'h100,     1,0,0, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,1,1,1, 32'h40,        8, 0,0,0, 1,32'h100,     0,0,0, 32'h44,       32'h20));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,1, 1,32'h100,     0,0,0, 32'h4,        32'h0));
    tbl.push_back(mk(1,0,0,0,0, 32'h0,         0, 0,0,0, 1,32'h104,     0,0,1, 32'h4,        32'h0));
    tbl.push_back(mk(0,0,0,0,0, 32'h0,         0, 0,0,0, 0,32'h100,     0,0,0, 32'h4,        32'h0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Misaligned redirect target: brPC 0x202 + 1 instruction = 0x206.
    apply(mk(0,1,0,1,0, 32'h202, 1, 0,0,1, 1,32'h100, 0,0,0, 32'h206, 32'h4), "mis0");
`ifdef PC_ALIGN_CHECK_EN
    chk("mis0.alignFault", 32'(alignFault), 32'h0);
    apply(mk(0,0,0,0,0, 32'h0, 0, 0,0,1, 0,32'h100, 0,1,1, 32'h4, 32'h0), "mis1");
    chk("mis1.alignFault", 32'(alignFault), 32'h1);
    apply(mk(0,1,0,1,0, 32'h300, 0, 0,0,1, 0,32'h100, 0,1,1, 32'h304, 32'h0), "mis2");
    chk("mis2.alignFault", 32'(alignFault), 32'h1);
`else
    apply(mk(0,0,0,0,0, 32'h0, 0, 0,0,0, 1,32'h206, 1,0,1, 32'h4, 32'h0), "mis1");
    apply(mk(0,0,0,0,0, 32'h0, 0, 0,0,1, 1,32'h206, 0,0,1, 32'h4, 32'h0), "mis2");
`endif

    // Randomized run against the behavioural model.
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset      = (cyc == 0) || ($urandom_range(0, 99) == 0);
      brValid    = ($urandom_range(0, 3) == 0);
      branchFlag = $urandom_range(0, 1) == 1;
      zeroFlag   = $urandom_range(0, 1) == 1;
      unconditionalBranchFlag = ($urandom_range(0, 2) == 0);
      brPC       = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
      PCOffsetOrig = ($urandom_range(0, 1) == 0) ? 26'($urandom)
                                                 : 26'($signed($urandom_range(0, 64)) - 32);
      stall      = ($urandom_range(0, 3) == 0);
      halt       = ($urandom_range(0, 49) == 0);
      fetchReady = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (cyc != 0) begin
        chk($sformatf("r%0d.fetchValid", cyc),  32'(fetchValid),  32'(m_mode == 1));
        chk($sformatf("r%0d.readAddress", cyc), readAddress,      m_pc);
        chk($sformatf("r%0d.takenBranch", cyc), 32'(takenBranch), 32'(m_taken));
        chk($sformatf("r%0d.halted", cyc),      32'(halted),      32'(m_mode == 2));
        chk($sformatf("r%0d.fetchCount", cyc),  32'(fetchCount),  32'(m_cnt));
        chk($sformatf("r%0d.linkAddress", cyc), linkAddress,      brPC + IB);
        chk($sformatf("r%0d.scaledOff", cyc),   PCScaledOffset,   ref_scaled(PCOffsetOrig));
`ifdef PC_ALIGN_CHECK_EN
        chk($sformatf("r%0d.alignFault", cyc),  32'(alignFault),  32'(m_fault));
`endif
      end
      model_step();
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
